// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
//   Shared widths, types and small arithmetic helpers for the Sobel gradient
//   block (sobel_gradient and sobel_pos_counter).
//
//   LAT    : fixed latency, window in -> pixel out (3 register stages)
//   SUM_W  : width of one weighted 1-2-1 column/row sum (max 4*255 = 1020)
//   MAG_W  : width of |Gx|+|Gy| (max 2040)
//   PIX_W  : pixel width
//   window_t : 3x3 window, row-major, index 1 = top-left, 9 = bottom-right
//   ctl_t    : video controls plus border mask carried alongside the data
// -----------------------------------------------------------------------------
package sobel_pkg;

  localparam int LAT   = 3;
  localparam int SUM_W = 10;
  localparam int MAG_W = 11;
  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] window_t [1:9];

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic mask;
  } ctl_t;

  // Counter width for a count range of n values; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // a + 2b + c, widened so the result cannot overflow.
  function automatic logic [SUM_W-1:0] tap121(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b,
    input logic [PIX_W-1:0] c
  );
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // |p - n| computed one bit wider as a signed difference.
  function automatic logic [SUM_W-1:0] abs_diff(
    input logic [SUM_W-1:0] p,
    input logic [SUM_W-1:0] n
  );
    logic signed [SUM_W:0] d;
    logic signed [SUM_W:0] neg_d;
    d     = $signed({1'b0, p}) - $signed({1'b0, n});
    neg_d = -d;
    return d[SUM_W] ? neg_d[SUM_W-1:0] : d[SUM_W-1:0];
  endfunction

  // Clamp an 11-bit magnitude into the 8-bit pixel range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic [MAG_W-1:0] m);
    return (m > MAG_W'(255)) ? {PIX_W{1'b1}} : m[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_pos_counter.sv
// -----------------------------------------------------------------------------
// sobel_pos_counter
//   Tracks the column and row of the window currently presented to the Sobel
//   pipeline and flags windows in the first two columns or first two rows,
//   which contain zero-fill from outside the frame.
//
//   Ports
//     clk       in  1  pixel clock
//     rst_n     in  1  asynchronous active-low reset
//     i_de      in  1  data enable aligned to the window
//     i_vsync   in  1  vsync aligned to the window
//     o_border  out 1  1 while the current window lies in the border band
//
//   col : cleared while de=0, +1 per de=1 cycle, holds at MAX_WIDTH-1
//   row : cleared on a vsync rise, +1 per de fall, holds at MAX_HEIGHT-1;
//         a vsync rise in the same cycle as a de fall clears the row.
// -----------------------------------------------------------------------------
module sobel_pos_counter
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH  = 2100,
  parameter int MAX_HEIGHT = 2100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_de,
  input  logic i_vsync,
  output logic o_border
);

  localparam int COL_W = cnt_w(MAX_WIDTH);
  localparam int ROW_W = cnt_w(MAX_HEIGHT);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MAX_HEIGHT - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_de_d;
  logic             r_vsync_d;
  logic             w_vs_rise;
  logic             w_de_fall;

  assign w_vs_rise = i_vsync & ~r_vsync_d;
  assign w_de_fall = ~i_de & r_de_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_de_d    <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_de_d    <= i_de;
      r_vsync_d <= i_vsync;

      if (!i_de) begin
        r_col <= '0;
      end else if (r_col != COL_MAX) begin
        r_col <= r_col + COL_W'(1);
      end

      // Frame start takes priority over a line end in the same cycle.
      if (w_vs_rise) begin
        r_row <= '0;
      end else if (w_de_fall && (r_row != ROW_MAX)) begin
        r_row <= r_row + ROW_W'(1);
      end
    end
  end

  // Counts reflect how many pixels/lines precede the current window, so the
  // first two of each are flagged.
  assign o_border = (r_col < COL_W'(2)) || (r_row < ROW_W'(2));

endmodule

// File: rtl/sobel_gradient.sv
// -----------------------------------------------------------------------------
// sobel_gradient
//   Sobel edge magnitude |Gx|+|Gy| over a 3x3 window in a 3-stage pipeline,
//   followed by a right shift, 8-bit saturation and border blanking. Video
//   controls travel with the data so they line up with the result pixel.
//
//   Parameters
//     MAX_WIDTH   max active pixels per line (column counter range)
//     MAX_HEIGHT  max active lines per frame (row counter range)
//     SHIFT       right shift of the 11-bit magnitude before saturation, 0..3
//
//   Ports
//     clk             in  1  pixel clock
//     rst_n           in  1  asynchronous active-low reset
//     win_p1..win_p9  in  8  window, row-major; p1..p3 oldest line, p9 newest
//     hsync_in        in  1  hsync aligned to the window
//     vsync_in        in  1  vsync aligned to the window
//     de_in           in  1  data enable aligned to the window
//     thresh          in  8  binarisation threshold
//     pixel_out       out 8  edge pixel
//     hsync_out       out 1  hsync delayed 3 cycles
//     vsync_out       out 1  vsync delayed 3 cycles
//     de_out          out 1  de delayed 3 cycles
//
//   Build option
//     SOBEL_THRESH_EN  when defined, the saturated magnitude is compared with
//                      thresh and the output becomes 8'hFF / 8'h00. When not
//                      defined, thresh is ignored and the grey level is output.
//
//   Pipeline
//     S1: xp=p3+2p6+p9  xn=p1+2p4+p7  yp=p7+2p8+p9  yn=p1+2p2+p3, border mask
//     S2: ax=|xp-xn|  ay=|yp-yn|
//     S3: m=(ax+ay)>>SHIFT, saturate, blank when de=0 or masked
// -----------------------------------------------------------------------------
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH  = 2100,
  parameter int MAX_HEIGHT = 2100,
  parameter int SHIFT      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] win_p1,
  input  logic [PIX_W-1:0] win_p2,
  input  logic [PIX_W-1:0] win_p3,
  input  logic [PIX_W-1:0] win_p4,
  input  logic [PIX_W-1:0] win_p5,
  input  logic [PIX_W-1:0] win_p6,
  input  logic [PIX_W-1:0] win_p7,
  input  logic [PIX_W-1:0] win_p8,
  input  logic [PIX_W-1:0] win_p9,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] pixel_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out
);

  // ---------------------------------------------------------------------------
  // Window gathering
  // ---------------------------------------------------------------------------
  window_t w_win;

  assign w_win[1] = win_p1;
  assign w_win[2] = win_p2;
  assign w_win[3] = win_p3;
  assign w_win[4] = win_p4;
  assign w_win[5] = win_p5;
  assign w_win[6] = win_p6;
  assign w_win[7] = win_p7;
  assign w_win[8] = win_p8;
  assign w_win[9] = win_p9;

  // ---------------------------------------------------------------------------
  // Position tracking / border mask
  // ---------------------------------------------------------------------------
  logic w_border;

  sobel_pos_counter #(
    .MAX_WIDTH  (MAX_WIDTH),
    .MAX_HEIGHT (MAX_HEIGHT)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_de     (de_in),
    .i_vsync  (vsync_in),
    .o_border (w_border)
  );

  // ---------------------------------------------------------------------------
  // S1: weighted sums
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] r_xp;
  logic [SUM_W-1:0] r_xn;
  logic [SUM_W-1:0] r_yp;
  logic [SUM_W-1:0] r_yn;
  ctl_t             r_ctl1;
  ctl_t             w_ctl_in;

  assign w_ctl_in = '{hsync: hsync_in, vsync: vsync_in, de: de_in, mask: w_border};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xp   <= '0;
      r_xn   <= '0;
      r_yp   <= '0;
      r_yn   <= '0;
      r_ctl1 <= '0;
    end else begin
      r_xp   <= tap121(w_win[3], w_win[6], w_win[9]);
      r_xn   <= tap121(w_win[1], w_win[4], w_win[7]);
      r_yp   <= tap121(w_win[7], w_win[8], w_win[9]);
      r_yn   <= tap121(w_win[1], w_win[2], w_win[3]);
      r_ctl1 <= w_ctl_in;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: absolute gradients
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] r_ax;
  logic [SUM_W-1:0] r_ay;
  ctl_t             r_ctl2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ax   <= '0;
      r_ay   <= '0;
      r_ctl2 <= '0;
    end else begin
      r_ax   <= abs_diff(r_xp, r_xn);
      r_ay   <= abs_diff(r_yp, r_yn);
      r_ctl2 <= r_ctl1;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: magnitude, scale, saturate, blank
  // ---------------------------------------------------------------------------
  logic [MAG_W-1:0] w_sum;
  logic [MAG_W-1:0] w_mag;
  logic [PIX_W-1:0] w_sat;
  logic [PIX_W-1:0] w_level;
  logic [PIX_W-1:0] w_pix;
  logic             w_unused;

  assign w_sum = MAG_W'(r_ax) + MAG_W'(r_ay);
  assign w_mag = w_sum >> SHIFT;
  assign w_sat = sat_pix(w_mag);

`ifdef SOBEL_THRESH_EN
  // Binarise on the saturated value so the threshold sees the 8-bit level.
  assign w_level  = (w_sat >= thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
  // The centre tap carries no weight in either Sobel kernel.
  assign w_unused = ^w_win[5];
`else
  assign w_level  = w_sat;
  assign w_unused = ^{w_win[5], thresh};
`endif

  // Windows outside active video or touching the zero-filled border give 0.
  assign w_pix = (r_ctl2.de && !r_ctl2.mask) ? w_level : {PIX_W{1'b0}};

  logic [PIX_W-1:0] r_pix_out;
  logic             r_hsync_out;
  logic             r_vsync_out;
  logic             r_de_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_out   <= '0;
      r_hsync_out <= 1'b0;
      r_vsync_out <= 1'b0;
      r_de_out    <= 1'b0;
    end else begin
      r_pix_out   <= w_pix;
      r_hsync_out <= r_ctl2.hsync;
      r_vsync_out <= r_ctl2.vsync;
      r_de_out    <= r_ctl2.de;
    end
  end

  assign pixel_out = r_pix_out;
  assign hsync_out = r_hsync_out;
  assign vsync_out = r_vsync_out;
  assign de_out    = r_de_out;

endmodule

// File: tb/tb_sobel_gradient.sv
// -----------------------------------------------------------------------------
// tb_sobel_gradient
//   Directed bench for sobel_gradient. Small MAX_WIDTH/MAX_HEIGHT so counter
//   saturation is reachable. Each step drives one window and, three cycles
//   later, compares all four outputs with the hand-computed expectation.
//   Build with +define+SOBEL_THRESH_EN to exercise the binarised output.
// -----------------------------------------------------------------------------
module tb_sobel_gradient;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8, win_p9;
  logic       hsync_in, vsync_in, de_in;
  logic [7:0] thresh;
  logic [7:0] pixel_out;
  logic       hsync_out, vsync_out, de_out;

  always #5 clk = ~clk;

  sobel_gradient #(
    .MAX_WIDTH  (8),
    .MAX_HEIGHT (4),
    .SHIFT      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .win_p1    (win_p1),
    .win_p2    (win_p2),
    .win_p3    (win_p3),
    .win_p4    (win_p4),
    .win_p5    (win_p5),
    .win_p6    (win_p6),
    .win_p7    (win_p7),
    .win_p8    (win_p8),
    .win_p9    (win_p9),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .de_in     (de_in),
    .thresh    (thresh),
    .pixel_out (pixel_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .de_out    (de_out)
  );

  // Windows packed {p1,p2,...,p9}; magnitude after >>2 noted per pattern.
  localparam logic [71:0] W_ZERO  = 72'd0;
  localparam logic [71:0] W_FLAT  = {9{8'd100}};                                        // 0
  localparam logic [71:0] W_VERT  = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};     // 1020/4=255
  localparam logic [71:0] W_DIAG  = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255}; // 1530/4=382 -> 255
  localparam logic [71:0] W_WEAK  = {8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10};        // 40/4=10
  localparam logic [71:0] W_WEAKN = {8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0};        // 40/4=10
  localparam logic [71:0] W_SMALL = {64'd0, 8'd7};                                       // 14/4=3

  int         checks = 0;
  int         errors = 0;
  int         step   = 0;
  logic [10:0] pipe1 = '0;   // {pixel, hsync, vsync, de} of the previous step
  logic [10:0] pipe2 = '0;   // ... of the step before that

  // Bottom row = a, rest 0: Gy = 4a, Gx = 0, so the magnitude is a.
  function automatic logic [71:0] horiz(input logic [7:0] a);
    return {48'd0, a, a, a};
  endfunction

  // Expected output for an unmasked active pixel of grey magnitude m.
  function automatic logic [7:0] ex(input logic [7:0] m);
`ifdef SOBEL_THRESH_EN
    return (m >= thresh) ? 8'hFF : 8'h00;
`else
    return m;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d observed %0h expected %0h", tag, step, obs, expv);
    end
  endtask

  task automatic chk_all(input logic [10:0] e);
    chk("pixel_out", pixel_out, e[10:3]);
    chk("hsync_out", {7'd0, hsync_out}, {7'd0, e[2]});
    chk("vsync_out", {7'd0, vsync_out}, {7'd0, e[1]});
    chk("de_out",    {7'd0, de_out},    {7'd0, e[0]});
  endtask

  // One pixel clock: drive, clock, check the result of two steps earlier.
  task automatic cyc(input logic [71:0] w, input logic h, input logic v,
                     input logic de, input logic [7:0] px);
    {win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8, win_p9} = w;
    hsync_in = h;
    vsync_in = v;
    de_in    = de;
    @(posedge clk);
    #1;
    chk_all(pipe2);
    $display("step %0d in h%0b v%0b de%0b exp_in %0d | out pix %0d h%0b v%0b de%0b",
             step, h, v, de, px, pixel_out, hsync_out, vsync_out, de_out);
    pipe2 = pipe1;
    pipe1 = {px, h, v, de};
    step++;
  endtask

  // n active pixels of one window then two blanking cycles (hsync in the
  // first, optionally vsync together with the de fall).
  task automatic line(input logic [71:0] w, input int n, input logic [7:0] m,
                      input logic masked, input logic vs_end);
    for (int i = 0; i < n; i++) begin
      cyc(w, 1'b0, 1'b0, 1'b1, (masked || i < 2) ? 8'd0 : ex(m));
    end
    cyc(w, 1'b1, vs_end, 1'b0, 8'd0);
    cyc(w, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    {win_p1, win_p2, win_p3, win_p4, win_p5, win_p6, win_p7, win_p8, win_p9} = W_ZERO;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    de_in    = 1'b0;
    thresh   = 8'd50;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all(11'd0);
    rst_n = 1'b1;

    // Frame start
    cyc(W_ZERO, 1'b0, 1'b1, 1'b0, 8'd0);
    cyc(W_ZERO, 1'b0, 1'b0, 1'b0, 8'd0);

    // Rows 0 and 1 are masked whatever the content
    line(W_VERT, 4, 8'd255, 1'b1, 1'b0);
    line(W_DIAG, 4, 8'd255, 1'b1, 1'b0);

    // Row 2: magnitude patterns; 12 pixels also runs col into saturation
    cyc(W_DIAG,     1'b0, 1'b0, 1'b1, 8'd0);
    cyc(W_DIAG,     1'b0, 1'b0, 1'b1, 8'd0);
    cyc(W_FLAT,     1'b0, 1'b0, 1'b1, ex(8'd0));
    cyc(W_VERT,     1'b0, 1'b0, 1'b1, ex(8'd255));
    cyc(W_DIAG,     1'b0, 1'b0, 1'b1, ex(8'd255));
    cyc(W_WEAK,     1'b0, 1'b0, 1'b1, ex(8'd10));
    cyc(W_WEAKN,    1'b0, 1'b0, 1'b1, ex(8'd10));
    cyc(W_SMALL,    1'b0, 1'b0, 1'b1, ex(8'd3));
    cyc(horiz(200), 1'b0, 1'b0, 1'b1, ex(8'd200));
    cyc(horiz(49),  1'b0, 1'b0, 1'b1, ex(8'd49));
    cyc(horiz(50),  1'b0, 1'b0, 1'b1, ex(8'd50));
    cyc(horiz(51),  1'b0, 1'b0, 1'b1, ex(8'd51));
    cyc(W_ZERO,     1'b1, 1'b0, 1'b0, 8'd0);
    cyc(W_ZERO,     1'b0, 1'b0, 1'b0, 8'd0);

    // Rows 3, then held at MAX_HEIGHT-1: stay unmasked
    line(W_DIAG, 4, 8'd255, 1'b0, 1'b0);
    line(W_DIAG, 4, 8'd255, 1'b0, 1'b0);
    line(W_DIAG, 4, 8'd255, 1'b0, 1'b0);

    // Control alignment through blanking, including vsync rises
    cyc(W_DIAG, 1'b1, 1'b1, 1'b0, 8'd0);
    cyc(W_DIAG, 1'b0, 1'b1, 1'b0, 8'd0);
    cyc(W_DIAG, 1'b1, 1'b0, 1'b0, 8'd0);
    cyc(W_DIAG, 1'b0, 1'b1, 1'b0, 8'd0);
    cyc(W_DIAG, 1'b1, 1'b1, 1'b0, 8'd0);
    cyc(W_DIAG, 1'b0, 1'b0, 1'b0, 8'd0);

    // New frame: rows 0,1 masked, row 2 open, row 3 ends with vsync + de fall
    line(W_DIAG, 4, 8'd255, 1'b1, 1'b0);
    line(W_DIAG, 4, 8'd255, 1'b1, 1'b0);
    line(W_DIAG, 4, 8'd255, 1'b0, 1'b0);
    line(W_DIAG, 4, 8'd255, 1'b0, 1'b1);
    // The row clear must have won: two masked lines again
    line(W_VERT, 4, 8'd255, 1'b1, 1'b0);
    line(W_VERT, 4, 8'd255, 1'b1, 1'b0);

    // Row 2, reset in the middle of the line
    for (int i = 0; i < 5; i++) begin
      cyc(W_DIAG, 1'b0, 1'b0, 1'b1, (i < 2) ? 8'd0 : ex(8'd255));
    end
    rst_n = 1'b0;
    #1;
    chk_all(11'd0);
    @(posedge clk);
    #1;
    chk_all(11'd0);
    rst_n = 1'b1;
    pipe1 = '0;
    pipe2 = '0;

    // After reset row=0: rest of line and next line masked, then edges return
    line(W_DIAG, 3, 8'd255, 1'b1, 1'b0);
    line(W_VERT, 4, 8'd255, 1'b1, 1'b0);
    line(W_VERT, 4, 8'd255, 1'b0, 1'b0);

    // Drain the pipeline
    repeat (3) cyc(W_ZERO, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
